ahb_master_req_gen: RTL and testbench
=====================================

# ahb_master_req_gen

Per-master request generator sitting directly upstream of the per-slave AHB arbiters. It decodes a master's address phase into a one-hot `hreq` toward the target slave's arbiter and stalls the master until that arbiter grants. It holds the request for the full burst by counting accepted beats, then releases it. One instance exists per master; bit *i* of `hreq`/`hgrant` connects to slave *i*'s arbiter port for this master.

## Interface
- `SLAVE_NUM`, 6: number of slave arbiters.
- `ADDR_WIDTH`, 32: master address width.
- `SEL_BIT`, `$clog2(SLAVE_NUM)`: top address bits used as the slave index.
- `hclk` in 1: clock. One clock domain.
- `hreset_n` in 1: reset, asynchronous, active-low.
- `htrans` in 2: master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- `haddr` in ADDR_WIDTH: master address.
- `hburst` in `hburst_type`: master burst type, from `AHB_package`.
- `hgrant` in SLAVE_NUM: per-slave grant for this master; already qualified by that slave's `~hwait`.
- `hreq` out SLAVE_NUM: one-hot request to the target slave's arbiter.
- `hready_out` out 1: ready to master; 0 stalls the master.
- `hresp_err` out 1: error response to master.

## Operation
- Slave index is `haddr[ADDR_WIDTH-1 -: SEL_BIT]`. It is latched into `target` on NONSEQ accepted in IDLE or ACTIVE.
- Beat limit is latched with `target`:
  - SINGLE = 0.
  - WRAP4/INCR4 = 3.
  - WRAP8/INCR8 = 7.
  - WRAP16/INCR16 = 15.
  - INCR = unbounded.
- Beat counter is 4-bit. It clears on each new NONSEQ.
- A beat is accepted when `hgrant[target]=1` and `htrans` is NONSEQ or SEQ.
- `hreq[i] = (state==REQ || state==ACTIVE) && target==i`. Outside those states `hreq` is all zero.
- States:
  - **IDLE**: `hready_out=1`.
    - On NONSEQ with an in-range index: `hready_out=0` (combinational), go to REQ.
    - Otherwise stay in IDLE.
  - **REQ**: `hready_out=0` until `hgrant[target]=1`. That cycle `hready_out=1`, beat 0 is accepted, and the counter sets to 1.
    - If limit is 0, go to IDLE.
    - Otherwise go to ACTIVE.
  - **ACTIVE**: `hready_out=hgrant[target]`.
    - SEQ accepted: counter +1. When the accepted beat index equals the limit, go to IDLE.
    - BUSY: counter and `hreq` are held.
    - IDLE from the master (early termination or end of INCR): go to IDLE.
    - NONSEQ from the master: re-decode and go to REQ. `hready_out=0` that cycle.
- Losing `hgrant` mid-burst (slave wait) only stalls the master. `hreq` stays asserted and the counter does not advance.

## Timing
- Reset values: state=IDLE, `hreq=0`, `hready_out=1`, `hresp_err=0`, `target=0`, counter=0.
- Reset asserted mid-burst returns to these values immediately (asynchronous).
- NONSEQ in IDLE at cycle N: `hreq` is high from N+1. With the arbiter's registered grant, the earliest acceptance is N+2.
- `hreq` drops the cycle after the last beat is accepted.
- Counter wrap: 16 beats of INCR at count 15 wrap to 0 with no effect. INCR ends only on master IDLE or NONSEQ.
- `hburst` is sampled only on NONSEQ. Changes during SEQ are ignored.

## Configuration
- Macro: `AHB_REQ_GEN_DEFAULT_SLAVE_EN`.
- Defined: a NONSEQ whose index is ≥ SLAVE_NUM enters ERR1, then ERR2, then IDLE. No `hreq` is raised.
  - ERR1: `hready_out=0`, `hresp_err=1`.
  - ERR2: `hready_out=1`, `hresp_err=1`.
- Undefined: an out-of-range index maps to slave SLAVE_NUM-1. `hresp_err` is tied to 0 and the ERR states do not exist.

## Test plan
- Reset, idle bus: `hreq=0`, `hready_out=1` for 10 cycles.
- SINGLE NONSEQ at cycle N to `haddr=0xA000_0000` (slave 5), `hgrant[5]` high from N+2:
  - `hreq=6'b100000` during N+1..N+2.
  - `hready_out` is 0 at N and N+1, and 1 at N+2.
  - `hreq=0` at N+3.
- INCR4 to slave 2 (`0x4000_0000`) with `hgrant[2]` low for 2 cycles mid-burst: exactly 4 beats accepted, and `hreq[2]` drops one cycle after the 4th.
- INCR8 with BUSY inserted after beat 3, then master IDLE after beat 5: counter holds during BUSY, and `hreq` clears the cycle after the IDLE.
- `hreset_n` pulsed low during beat 10 of INCR16: all outputs return to reset values in the same cycle, and the next NONSEQ restarts cleanly.
- `0xC000_0000` (index 6):
  - With the macro: `hresp_err=1` for 2 cycles, `hready_out` 0 then 1, `hreq=0`.
  - Without the macro: `hreq=6'b100000`.

Source files
------------

// File: rtl/ahb_master_req_gen.sv
// Per-master AHB request generator: decodes the target slave, requests its arbiter and holds the request for the burst.
// Optional macro AHB_REQ_GEN_DEFAULT_SLAVE_EN: out-of-range slave index gives a two-cycle ERROR response.
package AHB_package;
  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_type;
endpackage

module ahb_master_req_gen
  import AHB_package::*;
#(
  parameter int SLAVE_NUM  = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_BIT    = $clog2(SLAVE_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [1:0]            htrans,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  hburst_type            hburst,
  input  logic [SLAVE_NUM-1:0]  hgrant,
  output logic [SLAVE_NUM-1:0]  hreq,
  output logic                  hready_out,
  output logic                  hresp_err,
  output logic [2:0]            dbg_state_o,
  output logic [3:0]            dbg_beat_cnt_o
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [SEL_BIT-1:0] LAST_IDX = SEL_BIT'(SLAVE_NUM - 1);

`ifdef AHB_REQ_GEN_DEFAULT_SLAVE_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACTIVE = 3'd2
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [SEL_BIT-1:0] target_q, target_d;
  logic [3:0]         limit_q, limit_d;
  logic               unb_q, unb_d;
  logic [3:0]         cnt_q, cnt_d;

  logic [SEL_BIT-1:0]   addr_idx;
  logic                 in_range;
  logic                 bad_idx;
  logic [SEL_BIT-1:0]   dec_idx;
  logic [3:0]           dec_limit;
  logic                 dec_unb;
  logic [SLAVE_NUM-1:0] tgt_oh;
  logic                 gnt_tgt;
  logic                 load;
  logic                 unused_addr;

  assign addr_idx    = haddr[ADDR_WIDTH-1 -: SEL_BIT];
  assign in_range    = (addr_idx <= LAST_IDX);
  assign unused_addr = ^haddr[ADDR_WIDTH-SEL_BIT-1:0];

`ifdef AHB_REQ_GEN_DEFAULT_SLAVE_EN
  assign bad_idx = ~in_range;
  assign dec_idx = addr_idx;
`else
  // Unmapped addresses fall through to the last slave.
  assign bad_idx = 1'b0;
  assign dec_idx = in_range ? addr_idx : LAST_IDX;
`endif

  // Limit is the index of the last beat; INCR never ends on count.
  always_comb begin
    dec_limit = 4'd0;
    dec_unb   = 1'b0;
    case (hburst)
      SINGLE:         dec_limit = 4'd0;
      INCR:           dec_unb   = 1'b1;
      WRAP4, INCR4:   dec_limit = 4'd3;
      WRAP8, INCR8:   dec_limit = 4'd7;
      WRAP16, INCR16: dec_limit = 4'd15;
      default:        dec_limit = 4'd0;
    endcase
  end

  always_comb begin
    tgt_oh = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      tgt_oh[i] = (target_q == SEL_BIT'(i));
    end
  end

  assign gnt_tgt = |(hgrant & tgt_oh);
  assign hreq    = ((state_q == ST_REQ) || (state_q == ST_ACTIVE)) ? tgt_oh : '0;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    limit_d    = limit_q;
    unb_d      = unb_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    hready_out = 1'b1;
    hresp_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (htrans == TR_NONSEQ) begin
          cnt_d = 4'd0;
          if (bad_idx) begin
`ifdef AHB_REQ_GEN_DEFAULT_SLAVE_EN
            state_d = ST_ERR1;
`endif
          end else begin
            hready_out = 1'b0;
            load       = 1'b1;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        hready_out = gnt_tgt;
        if (gnt_tgt) begin
          cnt_d   = 4'd1;
          state_d = (!unb_q && limit_q == 4'd0) ? ST_IDLE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        hready_out = gnt_tgt;
        case (htrans)
          TR_NONSEQ: begin
            cnt_d = 4'd0;
            if (bad_idx) begin
`ifdef AHB_REQ_GEN_DEFAULT_SLAVE_EN
              state_d = ST_ERR1;
`endif
            end else begin
              hready_out = 1'b0;
              load       = 1'b1;
              state_d    = ST_REQ;
            end
          end
          TR_SEQ: begin
            // A stalled SEQ (grant low) neither counts nor ends the burst.
            if (gnt_tgt) begin
              cnt_d = cnt_q + 4'd1;
              if (!unb_q && cnt_q == limit_q) state_d = ST_IDLE;
            end
          end
          TR_IDLE: state_d = ST_IDLE;
          TR_BUSY: ;
          default: ;
        endcase
      end
`ifdef AHB_REQ_GEN_DEFAULT_SLAVE_EN
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp_err  = 1'b1;
        state_d    = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_err = 1'b1;
        state_d   = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      target_d = dec_idx;
      limit_d  = dec_limit;
      unb_d    = dec_unb;
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      limit_q  <= 4'd0;
      unb_q    <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      limit_q  <= limit_d;
      unb_q    <= unb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dbg_state_o    = state_q;
  assign dbg_beat_cnt_o = cnt_q;

endmodule

// File: tb/tb_ahb_master_req_gen.sv
// Bench for ahb_master_req_gen: per-cycle expected outputs queued by the driver, checked on the falling edge.
module tb_ahb_master_req_gen;
  import AHB_package::*;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [5:0] G0 = 6'b000001;
  localparam logic [5:0] G1 = 6'b000010;
  localparam logic [5:0] G2 = 6'b000100;
  localparam logic [5:0] G3 = 6'b001000;
  localparam logic [5:0] G5 = 6'b100000;
  localparam logic [5:0] G_NONE = 6'b000000;

  logic        clk;
  logic        hreset_n;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  hburst_type  hburst;
  logic [5:0]  hgrant;
  logic [5:0]  hreq;
  logic        hready_out;
  logic        hresp_err;
  logic [2:0]  dbg_state;
  logic [3:0]  dbg_cnt;

  // {hreq, hready_out, hresp_err, beat count}
  logic [11:0] exp_q[$];
  string       lbl_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  ahb_master_req_gen #(.SLAVE_NUM(6), .ADDR_WIDTH(32)) dut (
    .hclk           (clk),
    .hreset_n       (hreset_n),
    .htrans         (htrans),
    .haddr          (haddr),
    .hburst         (hburst),
    .hgrant         (hgrant),
    .hreq           (hreq),
    .hready_out     (hready_out),
    .hresp_err      (hresp_err),
    .dbg_state_o    (dbg_state),
    .dbg_beat_cnt_o (dbg_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: apply one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic [1:0] tr, input logic [31:0] ad, input hburst_type bu,
                      input logic [5:0] gr, input logic [5:0] e_req, input logic e_rdy,
                      input logic e_err, input logic [3:0] e_cnt, input string name);
    htrans = tr;
    haddr  = ad;
    hburst = bu;
    hgrant = gr;
    exp_q.push_back({e_req, e_rdy, e_err, e_cnt});
    lbl_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [11:0] e;
      logic [11:0] a;
      string       l;
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      a = {hreq, hready_out, hresp_err, dbg_cnt};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got hreq=%b rdy=%b err=%b cnt=%0d, expected hreq=%b rdy=%b err=%b cnt=%0d",
                 l, $time, a[11:6], a[5], a[4], a[3:0], e[11:6], e[5], e[4], e[3:0]);
      end
    end
  end

  initial begin
    hreset_n = 1'b0;
    htrans   = T_IDLE;
    haddr    = '0;
    hburst   = SINGLE;
    hgrant   = '0;
    @(posedge clk);
    #1;
    repeat (3) step(T_IDLE, 32'h0, SINGLE, G_NONE, 6'b0, 1'b1, 1'b0, 4'd0, "reset");
    hreset_n = 1'b1;
    repeat (10) step(T_IDLE, 32'h0, SINGLE, G_NONE, 6'b0, 1'b1, 1'b0, 4'd0, "idle_bus");

    // SINGLE to slave 5, grant two cycles after NONSEQ
    step(T_NS,   32'hA000_0000, SINGLE, G_NONE, 6'b0, 1'b0, 1'b0, 4'd0, "single_n");
    step(T_NS,   32'hA000_0000, SINGLE, G_NONE, G5,   1'b0, 1'b0, 4'd0, "single_n1");
    step(T_NS,   32'hA000_0000, SINGLE, G5,     G5,   1'b1, 1'b0, 4'd0, "single_n2");
    step(T_IDLE, 32'h0,         SINGLE, G_NONE, 6'b0, 1'b1, 1'b0, 4'd1, "single_n3");

    // INCR4 to slave 2 with a two-cycle wait; hburst changes mid-burst are ignored
    step(T_NS,  32'h4000_0000, INCR4,  G_NONE, 6'b0, 1'b0, 1'b0, 4'd1, "incr4_ns");
    step(T_NS,  32'h4000_0000, INCR4,  G_NONE, G2,   1'b0, 1'b0, 4'd0, "incr4_req");
    step(T_NS,  32'h4000_0000, INCR4,  G2,     G2,   1'b1, 1'b0, 4'd0, "incr4_b0");
    step(T_SEQ, 32'h4000_0004, INCR4,  G2,     G2,   1'b1, 1'b0, 4'd1, "incr4_b1");
    step(T_SEQ, 32'h4000_0008, SINGLE, G_NONE, G2,   1'b0, 1'b0, 4'd2, "incr4_wait1");
    step(T_SEQ, 32'h4000_0008, SINGLE, G_NONE, G2,   1'b0, 1'b0, 4'd2, "incr4_wait2");
    step(T_SEQ, 32'h4000_0008, SINGLE, G2,     G2,   1'b1, 1'b0, 4'd2, "incr4_b2");
    step(T_SEQ, 32'h4000_000C, SINGLE, G2,     G2,   1'b1, 1'b0, 4'd3, "incr4_b3");
    step(T_IDLE, 32'h0,        SINGLE, G2,     6'b0, 1'b1, 1'b0, 4'd4, "incr4_drop");

    // INCR8 to slave 1, BUSY after beat 3, master IDLE after beat 5
    step(T_NS,   32'h2000_0000, INCR8, G1, 6'b0, 1'b0, 1'b0, 4'd4, "incr8_ns");
    step(T_NS,   32'h2000_0000, INCR8, G1, G1,   1'b1, 1'b0, 4'd0, "incr8_b0");
    step(T_SEQ,  32'h2000_0004, INCR8, G1, G1,   1'b1, 1'b0, 4'd1, "incr8_b1");
    step(T_SEQ,  32'h2000_0008, INCR8, G1, G1,   1'b1, 1'b0, 4'd2, "incr8_b2");
    step(T_SEQ,  32'h2000_000C, INCR8, G1, G1,   1'b1, 1'b0, 4'd3, "incr8_b3");
    step(T_BUSY, 32'h2000_0010, INCR8, G1, G1,   1'b1, 1'b0, 4'd4, "incr8_busy1");
    step(T_BUSY, 32'h2000_0010, INCR8, G1, G1,   1'b1, 1'b0, 4'd4, "incr8_busy2");
    step(T_SEQ,  32'h2000_0010, INCR8, G1, G1,   1'b1, 1'b0, 4'd4, "incr8_b4");
    step(T_SEQ,  32'h2000_0014, INCR8, G1, G1,   1'b1, 1'b0, 4'd5, "incr8_b5");
    step(T_IDLE, 32'h0,         INCR8, G1, G1,   1'b1, 1'b0, 4'd6, "incr8_idle");
    step(T_IDLE, 32'h0,         INCR8, G1, 6'b0, 1'b1, 1'b0, 4'd6, "incr8_drop");

    // INCR16 to slave 3, reset pulsed during beat 10, then a clean SINGLE
    step(T_NS, 32'h6000_0000, INCR16, G3, 6'b0, 1'b0, 1'b0, 4'd6, "incr16_ns");
    step(T_NS, 32'h6000_0000, INCR16, G3, G3,   1'b1, 1'b0, 4'd0, "incr16_b0");
    for (int k = 1; k <= 9; k++)
      step(T_SEQ, 32'h6000_0000 + 32'(4 * k), INCR16, G3, G3, 1'b1, 1'b0, 4'(k), "incr16_beat");
    hreset_n = 1'b0;
    step(T_SEQ, 32'h6000_0028, INCR16, G3, 6'b0, 1'b1, 1'b0, 4'd0, "incr16_reset");
    hreset_n = 1'b1;
    step(T_IDLE, 32'h0,         SINGLE, G_NONE, 6'b0, 1'b1, 1'b0, 4'd0, "post_reset_idle");
    step(T_NS,   32'h6000_0000, SINGLE, G3,     6'b0, 1'b0, 1'b0, 4'd0, "restart_ns");
    step(T_NS,   32'h6000_0000, SINGLE, G3,     G3,   1'b1, 1'b0, 4'd0, "restart_b0");
    step(T_IDLE, 32'h0,         SINGLE, G_NONE, 6'b0, 1'b1, 1'b0, 4'd1, "restart_done");

    // INCR to slave 0 over 17 beats (count wraps), then NONSEQ to slave 5 from ACTIVE
    step(T_NS, 32'h0000_0000, INCR, G0, 6'b0, 1'b0, 1'b0, 4'd1, "incr_ns");
    step(T_NS, 32'h0000_0000, INCR, G0, G0,   1'b1, 1'b0, 4'd0, "incr_b0");
    for (int k = 1; k <= 16; k++)
      step(T_SEQ, 32'(4 * k), INCR, G0, G0, 1'b1, 1'b0, 4'(k), "incr_beat");
    step(T_NS,   32'hA000_0000, SINGLE, G0,     G0,   1'b0, 1'b0, 4'd1, "redecode_ns");
    step(T_NS,   32'hA000_0000, SINGLE, G5,     G5,   1'b1, 1'b0, 4'd0, "redecode_b0");
    step(T_IDLE, 32'h0,         SINGLE, G_NONE, 6'b0, 1'b1, 1'b0, 4'd1, "redecode_done");

    // Index 6 (no such slave)
`ifdef AHB_REQ_GEN_DEFAULT_SLAVE_EN
    step(T_NS,   32'hC000_0000, SINGLE, G_NONE, 6'b0, 1'b1, 1'b0, 4'd1, "oor_ns");
    step(T_IDLE, 32'h0,         SINGLE, G_NONE, 6'b0, 1'b0, 1'b1, 4'd0, "oor_err1");
    step(T_IDLE, 32'h0,         SINGLE, G_NONE, 6'b0, 1'b1, 1'b1, 4'd0, "oor_err2");
    step(T_IDLE, 32'h0,         SINGLE, G_NONE, 6'b0, 1'b1, 1'b0, 4'd0, "oor_done");
`else
    step(T_NS,   32'hC000_0000, SINGLE, G_NONE, 6'b0, 1'b0, 1'b0, 4'd1, "oor_ns");
    step(T_NS,   32'hC000_0000, SINGLE, G_NONE, G5,   1'b0, 1'b0, 4'd0, "oor_req");
    step(T_NS,   32'hC000_0000, SINGLE, G5,     G5,   1'b1, 1'b0, 4'd0, "oor_b0");
    step(T_IDLE, 32'h0,         SINGLE, G_NONE, 6'b0, 1'b1, 1'b0, 4'd1, "oor_done");
`endif

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
